// File: rtl/gf2_pkg.sv
// Shared definitions for the digit-serial GF(2)[x] multiplier: FSM encoding,
// parameter helpers and a reference carry-less multiply.
package gf2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Number of D-bit digits needed to cover a W-bit operand.
  function automatic int ndig(input int w, input int d);
    return (w + d - 1) / d;
  endfunction

  localparam int CLMUL_MAX = 64;

  // Reference carry-less product for operands up to CLMUL_MAX bits.
  function automatic logic [2*CLMUL_MAX-1:0] clmul_ref(input logic [CLMUL_MAX-1:0] a,
                                                       input logic [CLMUL_MAX-1:0] b);
    logic [2*CLMUL_MAX-1:0] acc;
    acc = '0;
    for (int i = 0; i < CLMUL_MAX; i++) begin
      if (b[i]) acc = acc ^ ({{CLMUL_MAX{1'b0}}, a} << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf2_mul_digit_serial_if.sv
// Operand/product handshake bundle for the digit-serial multiplier.
interface gf2_mul_digit_serial_if #(
  parameter int W = 27
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-2:0] y;

  // Producer of operands and consumer of the product.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y
  );

  // The multiplier itself.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/gf2_digit_mul.sv
// Combinational W x D carry-less partial product: XOR of D shifted copies of
// a, each masked by one bit of the digit.
module gf2_digit_mul
  import gf2_pkg::*;
#(
  parameter int W = 27,
  parameter int D = 9
) (
  input  logic [W-1:0]   a,
  input  logic [D-1:0]   digit,
  output logic [W+D-2:0] prod
);

  localparam int PW = W + D - 1;

  logic [PW-1:0] a_ext;

  assign a_ext = PW'(a);

  // Accumulate the masked, shifted copies of a.
  always_comb begin
    prod = '0;
    for (int i = 0; i < D; i++) begin
      if (digit[i]) prod = prod ^ (a_ext << i);
    end
  end

endmodule

// File: rtl/gf2_mul_digit_serial.sv
// Digit-serial carry-less multiplier. Horner evaluation over the digits of b,
// most significant digit first, one digit per clock; unreduced 2W-1 bit product.
module gf2_mul_digit_serial
  import gf2_pkg::*;
#(
  parameter int W = 27,
  parameter int D = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  gf2_mul_digit_serial_if.slave bus
);

  localparam int NDIG = ndig(W, D);
  localparam int CW   = clog2(NDIG + 1);
  localparam int BW   = NDIG * D;
  localparam int AW   = BW + W - 1;
  localparam int PW   = W + D - 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  state_e        state;
  state_e        state_next;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_reg;
  logic [BW-1:0] b_reg;
  logic [AW-1:0] acc;
  logic [D-1:0]  b_digit;
  logic [PW-1:0] pp;
  logic          accept;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.y         = acc[2*W-2:0];

  // Operands are taken only in IDLE and never alongside an abort.
  assign accept = bus.in_valid && (state == IDLE) && !clear;

  // Select the digit of b addressed by the down-counter.
  always_comb begin
    b_digit = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt == CW'(i)) b_digit = b_reg[i*D +: D];
    end
  end

  gf2_digit_mul #(
    .W (W),
    .D (D)
  ) u_digit_mul (
    .a     (a_reg),
    .digit (b_digit),
    .prod  (pp)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of process ordering.
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (cnt == '0)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Operand capture, digit counter and shift-accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand registers are plain flops, not a RAM, so they are
      // reset with everything else to give a defined y after reset.
      cnt   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
    end else if (clear) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      a_reg <= bus.a;
      b_reg <= BW'(bus.b);
      acc   <= '0;
      cnt   <= CNT_LAST;
    end else if (state == RUN) begin
      acc <= (acc << D) ^ AW'(pp);
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_gf2_mul_digit_serial.sv
// Bench for gf2_mul_digit_serial: three instances (27/9, 8/3 padded, 8/8
// degenerate), directed vector table, handshake/abort/reset sequences and
// random traffic against clmul_ref.
module tb_gf2_mul_digit_serial;
  import gf2_pkg::*;

  logic clk;
  logic rst_n;
  logic clear;

  int n_checks;
  int n_errors;

  gf2_mul_digit_serial_if #(.W(27)) bus27 ();
  gf2_mul_digit_serial_if #(.W(8))  bus83 ();
  gf2_mul_digit_serial_if #(.W(8))  bus88 ();

  gf2_mul_digit_serial #(.W(27), .D(9)) u27 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus27));
  gf2_mul_digit_serial #(.W(8),  .D(3)) u83 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus83));
  gf2_mul_digit_serial #(.W(8),  .D(8)) u88 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus88));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           sel;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] y;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [63:0] a,
                       input logic [63:0] b, input logic r);
    case (sel)
      0: begin bus27.in_valid = v; bus27.a = a[26:0]; bus27.b = b[26:0]; bus27.out_ready = r; end
      1: begin bus83.in_valid = v; bus83.a = a[7:0];  bus83.b = b[7:0];  bus83.out_ready = r; end
      default: begin bus88.in_valid = v; bus88.a = a[7:0]; bus88.b = b[7:0]; bus88.out_ready = r; end
    endcase
  endtask

  function automatic logic [127:0] get_y(input int sel);
    case (sel)
      0:       return 128'(bus27.y);
      1:       return 128'(bus83.y);
      default: return 128'(bus88.y);
    endcase
  endfunction

  function automatic logic get_ov(input int sel);
    case (sel)
      0:       return bus27.out_valid;
      1:       return bus83.out_valid;
      default: return bus88.out_valid;
    endcase
  endfunction

  function automatic logic get_ir(input int sel);
    case (sel)
      0:       return bus27.in_ready;
      1:       return bus83.in_ready;
      default: return bus88.in_ready;
    endcase
  endfunction

  function automatic logic [63:0] wmask(input int sel);
    return (sel == 0) ? 64'h7FF_FFFF : 64'hFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid; returns edges waited.
  task automatic wait_ov(input int sel, output int lat);
    lat = 0;
    while (!get_ov(sel) && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  // One full transaction with out_ready held high.
  task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                        input logic [127:0] exp_y, input int exp_lat, input string name);
    int lat;
    check({name, " in_ready before"}, 128'(get_ir(sel)), 128'd1);
    drive(sel, 1'b1, a, b, 1'b1);
    tick();
    drive(sel, 1'b0, ~a, ~b, 1'b1);
    wait_ov(sel, lat);
    check({name, " latency"}, 128'(lat), 128'(exp_lat));
    check({name, " y"}, get_y(sel), exp_y);
    tick();
    check({name, " out_valid after"}, 128'(get_ov(sel)), 128'd0);
    check({name, " in_ready after"}, 128'(get_ir(sel)), 128'd1);
  endtask

  // Count out_valid cycles over a short window; must be zero after an abort.
  task automatic expect_silent(input int sel, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (get_ov(sel)) seen++;
      tick();
    end
    check({name, " no out_valid"}, 128'(seen), 128'd0);
  endtask

  task automatic rand_run(input int sel, input int n);
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] exp_y;
    logic         r;
    bit           done;
    for (int k = 0; k < n; k++) begin
      a = {$urandom, $urandom} & wmask(sel);
      b = {$urandom, $urandom} & wmask(sel);
      exp_y = clmul_ref(a, b);
      if (!get_ir(sel)) check("rand in_ready", 128'(get_ir(sel)), 128'd1);
      drive(sel, 1'b1, a, b, 1'($urandom_range(0, 1)));
      tick();
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        r = 1'($urandom_range(0, 1));
        drive(sel, 1'b0, ~a, ~b, r);
        if (get_ov(sel) && r) begin
          check("rand y", get_y(sel), exp_y);
          done = 1'b1;
        end else begin
          tick();
        end
      end
      if (!done) check("rand timeout", 128'd0, 128'd1);
      tick();
    end
    drive(sel, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, '0, '0, 1'b1);

    vecs.push_back('{0, 64'd3,         64'd7,         128'h9,                 3});
    vecs.push_back('{0, 64'h4000000,   64'h4000000,   128'h10000000000000,    3});
    vecs.push_back('{0, 64'h7FFFFFF,   64'd1,         128'h7FFFFFF,           3});
    vecs.push_back('{0, 64'h7FFFFFF,   64'h7FFFFFF,   128'h15555555555555,    3});
    vecs.push_back('{0, 64'd5,         64'd5,         128'h11,                3});
    vecs.push_back('{0, 64'h100,       64'h100,       128'h10000,             3});
    vecs.push_back('{0, 64'h4000000,   64'd3,         128'hC000000,           3});
    vecs.push_back('{0, 64'd0,         64'h5A5A5A,    128'h0,                 3});
    vecs.push_back('{1, 64'hFF,        64'hFF,        128'h5555,              3});
    vecs.push_back('{1, 64'h80,        64'h80,        128'h4000,              3});
    vecs.push_back('{1, 64'h03,        64'h05,        128'hF,                 3});
    vecs.push_back('{2, 64'hFF,        64'hFF,        128'h5555,              1});
    vecs.push_back('{2, 64'h81,        64'h03,        128'h183,               1});

    // Reset state.
    #3;
    check("reset in_ready", 128'(bus27.in_ready), 128'd1);
    check("reset out_valid", 128'(bus27.out_valid), 128'd0);
    check("reset y", 128'(bus27.y), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vector table.
    foreach (vecs[i]) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Back-pressure: product held, new operands ignored, no accept on handshake.
    drive(0, 1'b1, 64'd3, 64'd3, 1'b0);
    tick();
    drive(0, 1'b0, '0, '0, 1'b0);
    wait_ov(0, lat);
    check("bp latency", 128'(lat), 128'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", 128'(bus27.out_valid), 128'd1);
      check("bp y", 128'(bus27.y), 128'h5);
      check("bp in_ready", 128'(bus27.in_ready), 128'd0);
      drive(0, 1'b1, 64'h123, 64'h456, 1'b0);
      tick();
    end
    drive(0, 1'b1, 64'h123, 64'h456, 1'b1);
    tick();
    drive(0, 1'b0, '0, '0, 1'b1);
    check("bp release out_valid", 128'(bus27.out_valid), 128'd0);
    check("bp release in_ready", 128'(bus27.in_ready), 128'd1);
    expect_silent(0, "bp no accept");

    // Abort on the second RUN cycle.
    drive(0, 1'b1, 64'd5, 64'd5, 1'b1);
    tick();
    drive(0, 1'b0, '0, '0, 1'b1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort run in_ready", 128'(bus27.in_ready), 128'd1);
    check("abort run y", 128'(bus27.y), 128'd0);
    expect_silent(0, "abort run");
    run_op(0, 64'd1, 64'd1, 128'd1, 3, "post abort");

    // Abort while a product is pending.
    drive(0, 1'b1, 64'd5, 64'd5, 1'b0);
    tick();
    drive(0, 1'b0, '0, '0, 1'b0);
    wait_ov(0, lat);
    check("abort done pending", 128'(bus27.out_valid), 128'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive(0, 1'b0, '0, '0, 1'b1);
    check("abort done out_valid", 128'(bus27.out_valid), 128'd0);
    check("abort done in_ready", 128'(bus27.in_ready), 128'd1);
    check("abort done y", 128'(bus27.y), 128'd0);

    // Abort coinciding with an accept: operands refused.
    drive(0, 1'b1, 64'd5, 64'd5, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive(0, 1'b0, '0, '0, 1'b1);
    check("abort accept in_ready", 128'(bus27.in_ready), 128'd1);
    expect_silent(0, "abort accept");
    run_op(0, 64'd3, 64'd7, 128'h9, 3, "post abort2");

    // Asynchronous reset mid-RUN.
    drive(0, 1'b1, 64'd3, 64'd7, 1'b1);
    tick();
    drive(0, 1'b0, '0, '0, 1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 128'(bus27.out_valid), 128'd0);
    check("async rst in_ready", 128'(bus27.in_ready), 128'd1);
    check("async rst y", 128'(bus27.y), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    expect_silent(0, "after rst");

    // Random traffic with consumer stalls.
    rand_run(0, 1000);
    rand_run(1, 200);
    rand_run(2, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
